// File: rtl/alu_share_arbiter.sv
// Shares one EX-stage ALU between the main pipeline (port 0) and the branch-compare unit (port 1).
// Fixed priority to port 0, a starvation counter that forces a port-1 grant, and a two-stage issue/result path.
module alu_share_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            p0_valid,
    output logic            p0_ready,
    input  logic [3:0]      p0_ctrl,
    input  logic [XLEN-1:0] p0_a,
    input  logic [XLEN-1:0] p0_b,
    input  logic            p1_valid,
    output logic            p1_ready,
    input  logic [3:0]      p1_ctrl,
    input  logic [XLEN-1:0] p1_a,
    input  logic [XLEN-1:0] p1_b,
    input  logic            flush,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    output logic            p0_resp_valid,
    output logic            p1_resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_zero
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]      starve_q, starve_d;
    logic            iss_valid_q, iss_valid_d;
    logic            iss_owner_q, iss_owner_d;
    logic [3:0]      alu_ctrl_q, alu_ctrl_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d;
    logic [XLEN-1:0] alu_b_q, alu_b_d;
    logic            p0_resp_valid_q, p0_resp_valid_d;
    logic            p1_resp_valid_q, p1_resp_valid_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic            resp_zero_q, resp_zero_d;
    logic            p0_req;
    logic            res_keep;

    // A flushing cycle withdraws port 0 from arbitration, so a waiting port-1 request wins.
    always_comb begin
        p0_req   = p0_valid & ~flush;
        p1_ready = rst_n & p1_valid & (~p0_req | (starve_q == LIMIT));
        p0_ready = rst_n & p0_req & ~p1_ready;
    end

    always_comb begin
        starve_d = 4'd0;
        if (p1_valid && !p1_ready) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
        end
    end

    // Operand registers only load on a grant so the ALU inputs stay quiet when idle.
    always_comb begin
        iss_valid_d = p0_ready | p1_ready;
        iss_owner_d = p1_ready;
        alu_ctrl_d  = alu_ctrl_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        if (p1_ready) begin
            alu_ctrl_d = p1_ctrl;
            alu_a_d    = p1_a;
            alu_b_d    = p1_b;
        end else if (p0_ready) begin
            alu_ctrl_d = p0_ctrl;
            alu_a_d    = p0_a;
            alu_b_d    = p0_b;
        end
    end

    // A port-0 op sitting in the issue stage during a flush never reaches the result stage.
    always_comb begin
        res_keep        = iss_valid_q & ~(flush & ~iss_owner_q);
        p0_resp_valid_d = res_keep & ~iss_owner_q;
        p1_resp_valid_d = res_keep & iss_owner_q;
        resp_data_d     = resp_data_q;
        resp_zero_d     = resp_zero_q;
        if (res_keep) begin
            resp_data_d = alu_result;
            resp_zero_d = (alu_result == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q        <= 4'd0;
            iss_valid_q     <= 1'b0;
            iss_owner_q     <= 1'b0;
            alu_ctrl_q      <= 4'b0000;
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            p0_resp_valid_q <= 1'b0;
            p1_resp_valid_q <= 1'b0;
            resp_data_q     <= '0;
            resp_zero_q     <= 1'b0;
        end else begin
            starve_q        <= starve_d;
            iss_valid_q     <= iss_valid_d;
            iss_owner_q     <= iss_owner_d;
            alu_ctrl_q      <= alu_ctrl_d;
            alu_a_q         <= alu_a_d;
            alu_b_q         <= alu_b_d;
            p0_resp_valid_q <= p0_resp_valid_d;
            p1_resp_valid_q <= p1_resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_zero_q     <= resp_zero_d;
        end
    end

    assign alu_ctrl      = alu_ctrl_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign p0_resp_valid = p0_resp_valid_q;
    assign p1_resp_valid = p1_resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_zero     = resp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: random two-port traffic with flushes and a mid-run reset,
// checked by a reference model feeding an expected queue and an independent response monitor.
module tb_alu_share_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
        logic [31:0] exp_edge;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            p0_valid = 1'b0, p1_valid = 1'b0, flush = 1'b0;
    logic            p0_ready, p1_ready;
    logic [3:0]      p0_ctrl = '0, p1_ctrl = '0;
    logic [XLEN-1:0] p0_a = '0, p0_b = '0, p1_a = '0, p1_b = '0;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_a, alu_b, alu_result, resp_data;
    logic            p0_resp_valid, p1_resp_valid, resp_zero;

    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    exp_t exp_q[$];

    // Model state: starvation run, last operands sent to the ALU, last response data.
    int              deny_run = 0;
    logic [3:0]      m_ctrl = '0;
    logic [XLEN-1:0] m_a = '0, m_b = '0;
    logic [XLEN-1:0] last_data = '0;

    alu_share_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_ctrl(p0_ctrl), .p0_a(p0_a), .p0_b(p0_b),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_ctrl(p1_ctrl), .p1_a(p1_a), .p1_b(p1_b),
        .flush(flush),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .p0_resp_valid(p0_resp_valid), .p1_resp_valid(p1_resp_valid),
        .resp_data(resp_data), .resp_zero(resp_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return {31'd0, $signed(a) < $signed(b)};
            4'b0011: return {31'd0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return $unsigned($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return a + b;
        endcase
    endfunction

    // The shared ALU the arbiter drives.
    always_comb alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference model: expected grants from the priority/starvation rules, scoreboard pushes.
    always @(negedge clk) begin
        if (rst_n) begin
            logic p0_eff, e0, e1;
            check("alu_ctrl", alu_ctrl, m_ctrl);
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            p0_eff = p0_valid & ~flush;
            e1 = p1_valid & (!p0_eff || deny_run == LIMIT);
            e0 = p0_eff & ~e1;
            check("p0_ready", p0_ready, e0);
            check("p1_ready", p1_ready, e1);
            if (flush) begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (!exp_q[i].owner && exp_q[i].exp_edge == 32'(edge_cnt + 1)) begin
                        exp_q.delete(i);
                        break;
                    end
                end
            end
            if (e1) begin
                exp_q.push_back('{1'b1, alu_fn(p1_ctrl, p1_a, p1_b), 32'(edge_cnt + 2)});
                m_ctrl = p1_ctrl; m_a = p1_a; m_b = p1_b;
            end else if (e0) begin
                exp_q.push_back('{1'b0, alu_fn(p0_ctrl, p0_a, p0_b), 32'(edge_cnt + 2)});
                m_ctrl = p0_ctrl; m_a = p0_a; m_b = p0_b;
            end
            if (p1_valid && !e1) deny_run = (deny_run < LIMIT) ? deny_run + 1 : LIMIT;
            else deny_run = 0;
        end
    end

    // Monitor: pops one expectation per presented response.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            if (p0_resp_valid && p1_resp_valid) begin
                checks++;
                errors++;
                $display("FAIL both_resp_valid: got 11 expected at most one");
            end
            if (p0_resp_valid || p1_resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got data %0h expected none", resp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_owner", p1_resp_valid, e.owner);
                    check("resp_data", resp_data, e.data);
                    check("resp_zero", resp_zero, e.data == 0);
                    check("resp_latency", 32'(edge_cnt), e.exp_edge);
                    last_data = e.data;
                end
            end else begin
                check("resp_data_hold", resp_data, last_data);
                if (exp_q.size() > 0 && exp_q[0].exp_edge <= 32'(edge_cnt)) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_resp: got none expected data %0h owner %0d", e.data, e.owner);
                end
            end
        end
    end

    task automatic drive(input logic v0, input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic fl);
        @(posedge clk);
        #1;
        p0_valid = v0; p0_ctrl = c0; p0_a = a0; p0_b = b0;
        p1_valid = v1; p1_ctrl = c1; p1_a = a1; p1_b = b1;
        flush = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic random_traffic(input int n);
        logic [3:0] codes [10];
        logic [3:0] bcodes[3];
        logic [31:0] a0, a1, b1;
        codes  = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
        bcodes = '{4'b0100, 4'b0010, 4'b0011};
        for (int i = 0; i < n; i++) begin
            a0 = $urandom;
            a1 = $urandom;
            b1 = ($urandom_range(0, 2) == 0) ? a1 : $urandom;
            drive($urandom_range(0, 3) != 0, codes[$urandom_range(0, 9)], a0, $urandom,
                  $urandom_range(0, 2) == 0, bcodes[$urandom_range(0, 2)], a1, b1,
                  $urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        #1;
        check("rst_p0_resp_valid", p0_resp_valid, 0);
        check("rst_p1_resp_valid", p1_resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_zero", resp_zero, 0);
        check("rst_alu_ctrl", alu_ctrl, 0);
        check("rst_p0_ready", p0_ready, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        drive(1, 4'b0000, 5, 7, 0, 0, 0, 0, 0);
        idle(4);
        drive(1, 4'b0000, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 4'b0100, 9, 9, 0);
        drive(1, 4'b0000, 2, 2, 0, 0, 0, 0, 0);
        idle(4);

        for (int i = 0; i < 15; i++) drive(1, 4'b0000, 32'(i), 100, 1, 4'b0011, 32'(i), 3, 0);
        idle(3);

        drive(1, 4'b0000, 40, 2, 0, 0, 0, 0, 0);
        drive(1, 4'b0000, 50, 2, 1, 4'b0100, 6, 6, 1);
        idle(4);

        random_traffic(400);

        drive(1, 4'b0111, 32'hf0, 32'h3c, 1, 4'b0010, 1, 2, 0);
        drive(1, 4'b0110, 32'h10, 32'h01, 1, 4'b0100, 3, 5, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_p0_resp_valid", p0_resp_valid, 0);
        check("async_p1_resp_valid", p1_resp_valid, 0);
        check("async_p0_ready", p0_ready, 0);
        check("async_p1_ready", p1_ready, 0);
        check("async_resp_data", resp_data, 0);
        p0_valid = 0; p1_valid = 0; flush = 0;
        exp_q.delete();
        deny_run = 0; m_ctrl = '0; m_a = '0; m_b = '0; last_data = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(3);

        random_traffic(300);
        idle(6);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single EX-stage ALU between two requesters.
  - Port 0: main pipeline operations, arithmetic and ld/st address generation.
  - Port 1: branch-compare unit. It issues XOR/SLT/SLTU-class ops and tests for a zero result.
- Arbitration: fixed priority to port 0, plus a starvation counter that forces a port-1 grant.
- Each accepted op flows through a registered issue stage, then a registered result stage. The response returns tagged to its owner, with a zero flag.

Parameters:
- XLEN, 32, operand/result width.
- STARVE_LIMIT, 4, consecutive cycles port 1 may be pending-and-denied before it is forced to win. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_valid  in  1  port-0 request valid.
- p0_ready  out  1  port-0 request accepted this cycle.
- p0_ctrl  in  4  port-0 ALU control code {inverse, funct3}.
- p0_a  in  XLEN  port-0 operand A.
- p0_b  in  XLEN  port-0 operand B.
- p1_valid  in  1  port-1 request valid.
- p1_ready  out  1  port-1 request accepted this cycle.
- p1_ctrl  in  4  port-1 ALU control code.
- p1_a  in  XLEN  port-1 operand A.
- p1_b  in  XLEN  port-1 operand B.
- flush  in  1  kills all in-flight port-0 ops (mispredict).
- alu_ctrl  out  4  to shared ALU, registered.
- alu_a  out  XLEN  to shared ALU, registered.
- alu_b  out  XLEN  to shared ALU, registered.
- alu_result  in  XLEN  combinational result from shared ALU.
- p0_resp_valid  out  1  port-0 result valid, 1-cycle pulse.
- p1_resp_valid  out  1  port-1 result valid, 1-cycle pulse.
- resp_data  out  XLEN  registered result.
- resp_zero  out  1  resp_data == 0.

Behaviour:
- Reset (async, rst_n low): all outputs 0.
  - alu_ctrl = 4'b0000 (ADD).
  - Issue-valid and result-valid flags = 0; owner bits = 0; starve_cnt = 0.
  - Clears immediately and mid-operation; any in-flight op is discarded.
- Grant is combinational from p0_valid, p1_valid, starve_cnt. No backpressure downstream; ALU accepts every cycle.
  - p1_ready = p1_valid & (~p0_valid | starve_cnt == STARVE_LIMIT).
  - p0_ready = p0_valid & ~p1_ready.
  - At most one ready high per cycle.
- Starvation counter:
  - Increments when p1_valid & ~p1_ready.
  - Clears to 0 on p1_ready, or when p1_valid = 0.
  - Saturates at STARVE_LIMIT.
- Issue stage, on each clk:
  - If a grant occurred, latch the winner's ctrl/a/b into alu_ctrl/alu_a/alu_b. Set iss_valid = 1 and iss_owner = winning port.
  - Otherwise iss_valid = 0, and alu_ctrl/a/b hold their previous values (no toggling when idle).
- Result stage, on each clk:
  - Latch resp_data <= alu_result and resp_zero <= (alu_result == 0) when iss_valid.
  - pN_resp_valid <= iss_valid & (iss_owner == N).
  - When iss_valid = 0, both resp_valid = 0 and resp_data holds.
- Latency: accept at edge k, response valid after edge k+2, i.e. 2 cycles. Throughput: 1 op/cycle total.
- Flush (sampled at clk):
  - Clears iss_valid if iss_owner == 0.
  - Clears p0_resp_valid in the same edge: a result stage about to present a port-0 op is suppressed.
  - p0_ready is forced 0 during a flush cycle.
  - Port-1 ops are unaffected.
  - Flush with a simultaneous p1 request: p1 still granted.
- Simultaneous p0_valid & p1_valid with starve_cnt < STARVE_LIMIT: port 0 wins.
- Operands are captured on acceptance only; requesters may change inputs after ready.

Test Plan:
- Reset, then p0 req ctrl=0000, a=5, b=7, with ALU model = add → p0_ready=1 at cycle 0; p0_resp_valid=1, resp_data=12, resp_zero=0 exactly 2 cycles later; p1_resp_valid=0.
- Back-to-back alternating single requests (p0 add 1+1, p1 XOR 9^9, p0 add 2+2) → responses on consecutive cycles: 2 (owner p0), 0 with resp_zero=1 (owner p1), 4 (owner p0).
- p0_valid and p1_valid held high continuously, STARVE_LIMIT=4 → p1_ready asserted on the 5th cycle only, then starve_cnt=0; the pattern repeats every 5 cycles.
- Issue p0 op, assert flush the next cycle → no p0_resp_valid pulse; a p1 op issued alongside the flush still returns after 2 cycles.
- Assert rst_n=0 asynchronously mid-cycle with ops in both stages → all resp_valid and readies drop immediately; no stale response after release.
- Idle cycles after a request → alu_a/alu_b/alu_ctrl unchanged, resp_valid both 0, resp_data holds its last value.
